// File: rtl/lru_stack_cache_if.sv
// ============================================================================
// Module   : lru_stack_cache_if
// Purpose  : Request/response/statistics bundle of the LRU stack cache.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface lru_stack_cache_if #(
  parameter int WAYS   = 16,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 20
);
  localparam int WAY_W = $clog2(WAYS);
  localparam int NLVL  = WAY_W + 1;

  logic                    req_valid;
  logic                    req_ready;
  logic [ADDR_W-1:0]       req_addr;
  logic                    req_write;
  logic                    clear_stats;
  logic                    resp_valid;
  logic                    resp_hit;
  logic [WAY_W:0]          resp_depth;
  logic                    evict_valid;
  logic [ADDR_W-1:0]       evict_addr;
  logic                    evict_dirty;
  logic [NLVL*CNT_W-1:0]   hit_cnt;
  logic [CNT_W-1:0]        miss_cnt;
  logic [CNT_W-1:0]        acc_cnt;

  modport master (
    output req_valid, req_addr, req_write, clear_stats,
    input  req_ready, resp_valid, resp_hit, resp_depth,
    input  evict_valid, evict_addr, evict_dirty, hit_cnt, miss_cnt, acc_cnt
  );

  modport slave (
    input  req_valid, req_addr, req_write, clear_stats,
    output req_ready, resp_valid, resp_hit, resp_depth,
    output evict_valid, evict_addr, evict_dirty, hit_cnt, miss_cnt, acc_cnt
  );
endinterface

`default_nettype wire

// File: rtl/lru_stack_cache.sv
// ============================================================================
// Module   : lru_stack_cache
// Purpose  : Set-associative cache model with a true-LRU stack per set and
//            per-associativity hit statistics from the hit's stack depth.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lru_stack_cache #(
  parameter int WAYS        = 16,
  parameter int SETS        = 512,
  parameter int BLOCK_BYTES = 16,
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 20
) (
  input  logic                clk,
  input  logic                rst,
  lru_stack_cache_if.slave    bus
);
  localparam int WAY_W = $clog2(WAYS);
  localparam int SET_W = $clog2(SETS);
  localparam int OFF_W = $clog2(BLOCK_BYTES);
  localparam int TAG_W = ADDR_W - SET_W - OFF_W;
  localparam int NLVL  = WAY_W + 1;
  localparam logic [WAY_W:0] MISS_DEPTH = (WAY_W+1)'(WAYS);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_UPDATE = 2'd2
  } state_t;

  state_t                        state_q;
  logic [SET_W-1:0]              set_q;
  logic [TAG_W-1:0]              tag_q;
  logic                          write_q;
  logic                          hit_q;
  logic [WAY_W-1:0]              pos_q;
  logic                          req_ready_q;
  logic                          resp_valid_q;
  logic                          resp_hit_q;
  logic [WAY_W:0]                resp_depth_q;
  logic                          evict_valid_q;
  logic [ADDR_W-1:0]             evict_addr_q;
  logic                          evict_dirty_q;
  logic [NLVL-1:0][CNT_W-1:0]    hit_cnt_q;
  logic [CNT_W-1:0]              miss_cnt_q;
  logic [CNT_W-1:0]              acc_cnt_q;

  // Way 0 is MRU, way WAYS-1 is LRU; only valid/dirty need a reset.
  logic [TAG_W-1:0]              tag_mem_q [SETS][WAYS];
  logic [SETS-1:0][WAYS-1:0]     vld_q;
  logic [SETS-1:0][WAYS-1:0]     drt_q;

  logic                          hit_d;
  logic [WAY_W-1:0]              pos_d;
  logic [TAG_W-1:0]              tag_d [WAYS];
  logic [WAYS-1:0]               vld_d;
  logic [WAYS-1:0]               drt_d;

  // Scanning from LRU towards MRU leaves the lowest matching depth.
  always_comb begin
    hit_d = 1'b0;
    pos_d = '0;
    for (int w = WAYS-1; w >= 0; w--) begin
      if (vld_q[set_q][w] && (tag_mem_q[set_q][w] == tag_q)) begin
        hit_d = 1'b1;
        pos_d = WAY_W'(w);
      end
    end
  end

  always_comb begin
    for (int w = 0; w < WAYS; w++) begin
      tag_d[w] = tag_mem_q[set_q][w];
    end
    vld_d = vld_q[set_q];
    drt_d = drt_q[set_q];
    for (int w = 1; w < WAYS; w++) begin
      if (!hit_q || (w <= int'(pos_q))) begin
        tag_d[w] = tag_mem_q[set_q][w-1];
        vld_d[w] = vld_q[set_q][w-1];
        drt_d[w] = drt_q[set_q][w-1];
      end
    end
    tag_d[0] = tag_q;
    vld_d[0] = 1'b1;
    drt_d[0] = write_q | (hit_q & drt_q[set_q][pos_q]);
  end

  always_ff @(posedge clk) begin
    if (state_q == S_UPDATE) begin
      for (int w = 0; w < WAYS; w++) begin
        tag_mem_q[set_q][w] <= tag_d[w];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      drt_q <= '0;
    end else if (state_q == S_UPDATE) begin
      vld_q[set_q] <= vld_d;
      drt_q[set_q] <= drt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      set_q         <= '0;
      tag_q         <= '0;
      write_q       <= 1'b0;
      hit_q         <= 1'b0;
      pos_q         <= '0;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_depth_q  <= '0;
      evict_valid_q <= 1'b0;
      evict_addr_q  <= '0;
      evict_dirty_q <= 1'b0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
      acc_cnt_q     <= '0;
    end else begin
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_depth_q  <= '0;
      evict_valid_q <= 1'b0;
      evict_addr_q  <= '0;
      evict_dirty_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            set_q       <= bus.req_addr[OFF_W +: SET_W];
            tag_q       <= bus.req_addr[ADDR_W-1 -: TAG_W];
            write_q     <= bus.req_write;
            req_ready_q <= 1'b0;
            state_q     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          hit_q   <= hit_d;
          pos_q   <= pos_d;
          state_q <= S_UPDATE;
        end
        S_UPDATE: begin
          resp_valid_q <= 1'b1;
          resp_hit_q   <= hit_q;
          resp_depth_q <= hit_q ? {1'b0, pos_q} : MISS_DEPTH;
          if (!hit_q && vld_q[set_q][WAYS-1]) begin
            evict_valid_q <= 1'b1;
            evict_addr_q  <= {tag_mem_q[set_q][WAYS-1], set_q, {OFF_W{1'b0}}};
            evict_dirty_q <= drt_q[set_q][WAYS-1];
          end
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase

      // A hit at depth p is also a hit in every cache with more than p ways.
      if (bus.clear_stats) begin
        hit_cnt_q  <= '0;
        miss_cnt_q <= '0;
        acc_cnt_q  <= '0;
      end else if (state_q == S_UPDATE) begin
        if (acc_cnt_q != '1) acc_cnt_q <= acc_cnt_q + CNT_W'(1);
        if (hit_q) begin
          for (int k = 0; k < NLVL; k++) begin
            if ((int'(pos_q) < (1 << k)) && (hit_cnt_q[k] != '1)) begin
              hit_cnt_q[k] <= hit_cnt_q[k] + CNT_W'(1);
            end
          end
        end else if (miss_cnt_q != '1) begin
          miss_cnt_q <= miss_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_hit    = resp_hit_q;
  assign bus.resp_depth  = resp_depth_q;
  assign bus.evict_valid = evict_valid_q;
  assign bus.evict_addr  = evict_addr_q;
  assign bus.evict_dirty = evict_dirty_q;
  assign bus.hit_cnt     = hit_cnt_q;
  assign bus.miss_cnt    = miss_cnt_q;
  assign bus.acc_cnt     = acc_cnt_q;

endmodule

`default_nettype wire
